// File: rtl/decode_stage_if.sv
// Bundle between the IF/ID register, the register file, writeback and the ID/EX outputs of decode_stage.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_stage_if;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        LoadUseStall;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic        ValidE;
  logic        IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, FlushE, RegWriteW, RdW, ResultW, RD1, RD2,
    output A1, A2, LoadUseStall,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE,
    output ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, FlushE, RegWriteW, RdW, ResultW, RD1, RD2,
    input  A1, A2, LoadUseStall,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, IllegalE,
    input  ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I ID stage: control decode, immediate generation, WB bypass and the ID/EX register,
// with load-use bubble insertion and flush.
module decode_stage #(
  parameter bit BYPASS_EN    = 1'b1,
  parameter bit NOP_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_a1;
  logic [4:0]  w_a2;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;

  assign w_instr  = bus.InstrD;
  assign w_opcode = w_instr[6:0];
  assign w_funct3 = w_instr[14:12];
  assign w_a1     = w_instr[19:15];
  assign w_a2     = w_instr[24:20];
  assign w_rd     = w_instr[11:7];
  assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

  assign bus.A1 = w_a1;
  assign bus.A2 = w_a2;

  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_jump;
  logic        w_branch;
  logic        w_alu_src;
  logic [1:0]  w_result_src;
  logic [2:0]  w_alu_ctrl;
  logic [31:0] w_imm;
  logic        w_illegal;
  logic        w_uses_rs1;
  logic        w_uses_rs2;

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_ctrl   = ALU_ADD;
    w_imm        = 32'd0;
    w_illegal    = 1'b0;
    w_uses_rs1   = 1'b0;
    w_uses_rs2   = 1'b0;
    case (w_opcode)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = 2'b01;
        w_imm        = w_imm_i;
        w_uses_rs1   = 1'b1;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_s;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OP_R, OP_I: begin
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = (w_opcode == OP_R);
        w_alu_src   = (w_opcode == OP_I);
        w_imm       = (w_opcode == OP_I) ? w_imm_i : 32'd0;
        case (w_funct3)
          // funct7[5] selects sub only for register-register; addi ignores it
          3'b000:  w_alu_ctrl = ((w_opcode == OP_R) && w_instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  w_alu_ctrl = ALU_SLT;
          3'b110:  w_alu_ctrl = ALU_OR;
          3'b111:  w_alu_ctrl = ALU_AND;
          default: begin
            w_illegal   = 1'b1;
            w_reg_write = 1'b0;
          end
        endcase
      end
      OP_BEQ: begin
        w_branch   = 1'b1;
        w_alu_ctrl = ALU_SUB;
        w_imm      = w_imm_b;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = 2'b10;
        w_imm        = w_imm_j;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Register-file read ports with optional same-cycle WB forwarding
  logic [4:0]  w_port_addr [2];
  logic [31:0] w_port_rd   [2];
  logic [31:0] w_port_opnd [2];

  assign w_port_addr[0] = w_a1;
  assign w_port_addr[1] = w_a2;
  assign w_port_rd[0]   = bus.RD1;
  assign w_port_rd[1]   = bus.RD2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      if (BYPASS_EN) begin : g_bypass
        assign w_port_opnd[gi] = (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == w_port_addr[gi]))
                                 ? bus.ResultW : w_port_rd[gi];
      end else begin : g_direct
        assign w_port_opnd[gi] = w_port_rd[gi];
      end
    end
  endgenerate

  logic        r_reg_write;
  logic        r_mem_write;
  logic        r_jump;
  logic        r_branch;
  logic        r_alu_src;
  logic        r_valid;
  logic        r_illegal;
  logic [1:0]  r_result_src;
  logic [2:0]  r_alu_ctrl;
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic [31:0] r_imm;
  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;

  logic w_hazard_rs1;
  logic w_hazard_rs2;
  logic w_load_use_stall;
  logic w_load;
  logic w_load_datapath;

  // Hazard only against a load already latched in EX; a bubble there (ValidE=0) never stalls
  assign w_hazard_rs1     = w_uses_rs1 && (r_rd == w_a1);
  assign w_hazard_rs2     = w_uses_rs2 && (r_rd == w_a2);
  assign w_load_use_stall = r_valid && r_reg_write && (r_result_src == 2'b01) && (r_rd != 5'd0)
                            && (w_hazard_rs1 || w_hazard_rs2);
  assign w_load           = bus.ValidD && !bus.FlushE && !w_load_use_stall;
  assign w_load_datapath  = w_load || !NOP_ON_RESET;

  assign bus.LoadUseStall = w_load_use_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_jump       <= 1'b0;
      r_branch     <= 1'b0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_ctrl   <= 3'b000;
      r_rd1        <= 32'd0;
      r_rd2        <= 32'd0;
      r_imm        <= 32'd0;
      r_pc         <= 32'd0;
      r_pc_plus4   <= 32'd0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
    end else begin
      r_valid     <= w_load;
      r_reg_write <= w_load && w_reg_write;
      r_mem_write <= w_load && w_mem_write;
      r_jump      <= w_load && w_jump;
      r_branch    <= w_load && w_branch;
      r_illegal   <= w_load && w_illegal;
      if (w_load_datapath) begin
        r_alu_src    <= w_alu_src;
        r_result_src <= w_result_src;
        r_alu_ctrl   <= w_alu_ctrl;
        r_rd1        <= w_port_opnd[0];
        r_rd2        <= w_port_opnd[1];
        r_imm        <= w_imm;
        r_pc         <= bus.PCD;
        r_pc_plus4   <= bus.PCPlus4D;
        r_rs1        <= w_a1;
        r_rs2        <= w_a2;
        r_rd         <= w_rd;
      end else begin
        r_alu_src    <= 1'b0;
        r_result_src <= 2'b00;
        r_alu_ctrl   <= 3'b000;
        r_rd1        <= 32'd0;
        r_rd2        <= 32'd0;
        r_imm        <= 32'd0;
        r_pc         <= 32'd0;
        r_pc_plus4   <= 32'd0;
        r_rs1        <= 5'd0;
        r_rs2        <= 5'd0;
        r_rd         <= 5'd0;
      end
    end
  end

  assign bus.RegWriteE   = r_reg_write;
  assign bus.MemWriteE   = r_mem_write;
  assign bus.JumpE       = r_jump;
  assign bus.BranchE     = r_branch;
  assign bus.ALUSrcE     = r_alu_src;
  assign bus.ValidE      = r_valid;
  assign bus.IllegalE    = r_illegal;
  assign bus.ResultSrcE  = r_result_src;
  assign bus.ALUControlE = r_alu_ctrl;
  assign bus.RD1E        = r_rd1;
  assign bus.RD2E        = r_rd2;
  assign bus.ImmExtE     = r_imm;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc_plus4;
  assign bus.Rs1E        = r_rs1;
  assign bus.Rs2E        = r_rs2;
  assign bus.RdE         = r_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one task per scenario, hand-computed expectations.
// A second instance with BYPASS_EN=0 shares the stimulus for the no-bypass case.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pcd, pcp4, rd1, rd2, resw;
  logic        validd, flush, regww;
  logic [4:0]  rdw;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0080A283; // lw x5,8(x1)
  localparam logic [31:0] I_ADD6 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] I_JAL  = 32'h000283EF; // jal x7,0x28000 (A1 field = 5)

  always #5 clk = ~clk;

  decode_stage_if bus0 ();
  decode_stage_if bus1 ();

  assign bus0.InstrD = instr;   assign bus1.InstrD = instr;
  assign bus0.PCD = pcd;        assign bus1.PCD = pcd;
  assign bus0.PCPlus4D = pcp4;  assign bus1.PCPlus4D = pcp4;
  assign bus0.ValidD = validd;  assign bus1.ValidD = validd;
  assign bus0.FlushE = flush;   assign bus1.FlushE = flush;
  assign bus0.RegWriteW = regww; assign bus1.RegWriteW = regww;
  assign bus0.RdW = rdw;        assign bus1.RdW = rdw;
  assign bus0.ResultW = resw;   assign bus1.ResultW = resw;
  assign bus0.RD1 = rd1;        assign bus1.RD1 = rd1;
  assign bus0.RD2 = rd2;        assign bus1.RD2 = rd2;

  decode_stage #(.BYPASS_EN(1'b1), .NOP_ON_RESET(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus0));
  decode_stage #(.BYPASS_EN(1'b0), .NOP_ON_RESET(1'b1)) dut_nobyp (.clk(clk), .rst(rst), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] i, input logic v);
    instr = i; validd = v; pcd = 32'h100; pcp4 = 32'h104;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; regww = 1'b0; rdw = 5'd0; resw = 32'd0;
    rd1 = 32'h55; rd2 = 32'h66;
    present(I_ADD, 1'b1);
    tick(); tick();
    $display("txn reset: ValidE=%0d RD1E=%h PCE=%h", bus0.ValidE, bus0.RD1E, bus0.PCE);
    checks++; if (bus0.ValidE !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", bus0.ValidE); end
    checks++; if (bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0d want 0", bus0.RegWriteE); end
    checks++; if (bus0.RD1E !== 32'd0) begin errors++; $display("FAIL reset_rd1e: got %h want 0", bus0.RD1E); end
    checks++; if (bus0.PCE !== 32'd0) begin errors++; $display("FAIL reset_pce: got %h want 0", bus0.PCE); end
    checks++; if (bus0.RdE !== 5'd0) begin errors++; $display("FAIL reset_rde: got %0d want 0", bus0.RdE); end
    checks++; if (bus0.LoadUseStall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus0.LoadUseStall); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    rd1 = 32'd5; rd2 = 32'd7;
    present(I_ADD, 1'b1);
    tick();
    $display("txn add: ValidE=%0d RegWriteE=%0d ALU=%b RD1E=%h RD2E=%h RdE=%0d Imm=%h",
             bus0.ValidE, bus0.RegWriteE, bus0.ALUControlE, bus0.RD1E, bus0.RD2E, bus0.RdE, bus0.ImmExtE);
    checks++; if (bus0.ValidE !== 1'b1) begin errors++; $display("FAIL add_valid: got %0d want 1", bus0.ValidE); end
    checks++; if (bus0.RegWriteE !== 1'b1) begin errors++; $display("FAIL add_regwrite: got %0d want 1", bus0.RegWriteE); end
    checks++; if (bus0.ALUControlE !== 3'b000) begin errors++; $display("FAIL add_alu: got %b want 000", bus0.ALUControlE); end
    checks++; if (bus0.RD1E !== 32'd5) begin errors++; $display("FAIL add_rd1e: got %h want 5", bus0.RD1E); end
    checks++; if (bus0.RD2E !== 32'd7) begin errors++; $display("FAIL add_rd2e: got %h want 7", bus0.RD2E); end
    checks++; if (bus0.RdE !== 5'd3) begin errors++; $display("FAIL add_rde: got %0d want 3", bus0.RdE); end
    checks++; if (bus0.ImmExtE !== 32'd0) begin errors++; $display("FAIL add_imm: got %h want 0", bus0.ImmExtE); end
    checks++; if (bus0.Rs1E !== 5'd1 || bus0.Rs2E !== 5'd2) begin errors++; $display("FAIL add_rs: got %0d/%0d want 1/2", bus0.Rs1E, bus0.Rs2E); end
    checks++; if (bus0.PCE !== 32'h100 || bus0.PCPlus4E !== 32'h104) begin errors++; $display("FAIL add_pc: got %h/%h want 100/104", bus0.PCE, bus0.PCPlus4E); end
  endtask

  task automatic test_store_branch();
    present(32'hFE512E23, 1'b1);
    tick();
    $display("txn sw: Imm=%h MemWriteE=%0d RegWriteE=%0d ALUSrcE=%0d RdE=%0d", bus0.ImmExtE, bus0.MemWriteE, bus0.RegWriteE, bus0.ALUSrcE, bus0.RdE);
    checks++; if (bus0.ImmExtE !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm: got %h want fffffffc", bus0.ImmExtE); end
    checks++; if (bus0.MemWriteE !== 1'b1) begin errors++; $display("FAIL sw_memwrite: got %0d want 1", bus0.MemWriteE); end
    checks++; if (bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL sw_regwrite: got %0d want 0", bus0.RegWriteE); end
    checks++; if (bus0.ALUSrcE !== 1'b1) begin errors++; $display("FAIL sw_alusrc: got %0d want 1", bus0.ALUSrcE); end
    checks++; if (bus0.RdE !== 5'd28) begin errors++; $display("FAIL sw_rde: got %0d want 28", bus0.RdE); end
    present(32'hFE208CE3, 1'b1);
    tick();
    $display("txn beq: Imm=%h BranchE=%0d ALU=%b", bus0.ImmExtE, bus0.BranchE, bus0.ALUControlE);
    checks++; if (bus0.ImmExtE !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm: got %h want fffffff8", bus0.ImmExtE); end
    checks++; if (bus0.BranchE !== 1'b1) begin errors++; $display("FAIL beq_branch: got %0d want 1", bus0.BranchE); end
    checks++; if (bus0.ALUControlE !== 3'b001) begin errors++; $display("FAIL beq_alu: got %b want 001", bus0.ALUControlE); end
    checks++; if (bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL beq_regwrite: got %0d want 0", bus0.RegWriteE); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] t_instr [5] = '{32'h402081B3, 32'h0020A1B3, 32'h0020F1B3, 32'hFFF0E213, 32'hC0008093};
    logic [2:0]  t_alu   [5] = '{3'b001, 3'b101, 3'b010, 3'b011, 3'b000};
    logic        t_src   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_imm   [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFC00};
    for (int k = 0; k < 5; k++) begin
      present(t_instr[k], 1'b1);
      tick();
      $display("txn alu[%0d] instr=%h ALU=%b ALUSrc=%0d Imm=%h", k, t_instr[k], bus0.ALUControlE, bus0.ALUSrcE, bus0.ImmExtE);
      checks++; if (bus0.ALUControlE !== t_alu[k]) begin errors++; $display("FAIL alu_ctrl[%0d]: got %b want %b", k, bus0.ALUControlE, t_alu[k]); end
      checks++; if (bus0.ALUSrcE !== t_src[k]) begin errors++; $display("FAIL alu_src[%0d]: got %0d want %0d", k, bus0.ALUSrcE, t_src[k]); end
      checks++; if (bus0.ImmExtE !== t_imm[k]) begin errors++; $display("FAIL alu_imm[%0d]: got %h want %h", k, bus0.ImmExtE, t_imm[k]); end
      checks++; if (bus0.RegWriteE !== 1'b1) begin errors++; $display("FAIL alu_regwrite[%0d]: got %0d want 1", k, bus0.RegWriteE); end
    end
  endtask

  task automatic test_bypass();
    rd1 = 32'h11; rd2 = 32'h22; regww = 1'b1; rdw = 5'd1; resw = 32'hDEADBEEF;
    present(I_ADD, 1'b1);
    tick();
    $display("txn bypass rdw=1: RD1E=%h RD2E=%h nobypass RD1E=%h", bus0.RD1E, bus0.RD2E, bus1.RD1E);
    checks++; if (bus0.RD1E !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rd1e: got %h want deadbeef", bus0.RD1E); end
    checks++; if (bus0.RD2E !== 32'h22) begin errors++; $display("FAIL byp_rd2e_nomatch: got %h want 22", bus0.RD2E); end
    checks++; if (bus1.RD1E !== 32'h11) begin errors++; $display("FAIL nobyp_rd1e: got %h want 11", bus1.RD1E); end
    rdw = 5'd0;
    tick();
    $display("txn bypass rdw=0: RD1E=%h", bus0.RD1E);
    checks++; if (bus0.RD1E !== 32'h11) begin errors++; $display("FAIL byp_rd0: got %h want 11", bus0.RD1E); end
    rdw = 5'd2;
    tick();
    $display("txn bypass rdw=2: RD1E=%h RD2E=%h", bus0.RD1E, bus0.RD2E);
    checks++; if (bus0.RD2E !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rd2e: got %h want deadbeef", bus0.RD2E); end
    checks++; if (bus0.RD1E !== 32'h11) begin errors++; $display("FAIL byp_rd1e_nomatch: got %h want 11", bus0.RD1E); end
    regww = 1'b0;
    tick();
    checks++; if (bus0.RD2E !== 32'h22) begin errors++; $display("FAIL byp_we0: got %h want 22", bus0.RD2E); end
    $display("txn bypass we=0: RD2E=%h", bus0.RD2E);
    regww = 1'b0; rdw = 5'd0;
  endtask

  task automatic test_load_use();
    present(I_LW, 1'b1);
    tick();
    $display("txn lw: ValidE=%0d ResultSrcE=%b Imm=%h RdE=%0d", bus0.ValidE, bus0.ResultSrcE, bus0.ImmExtE, bus0.RdE);
    checks++; if (bus0.ResultSrcE !== 2'b01 || bus0.ImmExtE !== 32'd8 || bus0.ALUSrcE !== 1'b1) begin
      errors++; $display("FAIL lw_decode: got rs=%b imm=%h src=%0d want 01/8/1", bus0.ResultSrcE, bus0.ImmExtE, bus0.ALUSrcE); end
    present(I_ADD6, 1'b1);
    #1;
    checks++; if (bus0.LoadUseStall !== 1'b1) begin errors++; $display("FAIL lu_stall_hi: got %0d want 1", bus0.LoadUseStall); end
    tick();
    $display("txn add-after-lw stall cycle: ValidE=%0d Stall=%0d", bus0.ValidE, bus0.LoadUseStall);
    checks++; if (bus0.ValidE !== 1'b0 || bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL lu_bubble: got valid=%0d we=%0d want 0/0", bus0.ValidE, bus0.RegWriteE); end
    checks++; if (bus0.LoadUseStall !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %0d want 0", bus0.LoadUseStall); end
    tick();
    $display("txn held add: ValidE=%0d Rs1E=%0d RdE=%0d", bus0.ValidE, bus0.Rs1E, bus0.RdE);
    checks++; if (bus0.ValidE !== 1'b1 || bus0.Rs1E !== 5'd5 || bus0.RdE !== 5'd6) begin
      errors++; $display("FAIL lu_release: got valid=%0d rs1=%0d rd=%0d want 1/5/6", bus0.ValidE, bus0.Rs1E, bus0.RdE); end
    present(I_LW, 1'b1);
    tick();
    present(I_JAL, 1'b1);
    #1;
    checks++; if (bus0.LoadUseStall !== 1'b0) begin errors++; $display("FAIL jal_nostall: got %0d want 0", bus0.LoadUseStall); end
    tick();
    $display("txn jal after lw: ValidE=%0d JumpE=%0d ResultSrcE=%b Imm=%h", bus0.ValidE, bus0.JumpE, bus0.ResultSrcE, bus0.ImmExtE);
    checks++; if (bus0.ValidE !== 1'b1 || bus0.JumpE !== 1'b1 || bus0.ResultSrcE !== 2'b10 || bus0.RegWriteE !== 1'b1) begin
      errors++; $display("FAIL jal_ctrl: got v=%0d j=%0d rs=%b we=%0d want 1/1/10/1", bus0.ValidE, bus0.JumpE, bus0.ResultSrcE, bus0.RegWriteE); end
    checks++; if (bus0.ImmExtE !== 32'h00028000 || bus0.RdE !== 5'd7) begin errors++; $display("FAIL jal_imm: got %h rd=%0d want 00028000/7", bus0.ImmExtE, bus0.RdE); end
  endtask

  task automatic test_flush();
    present(I_ADD, 1'b1); flush = 1'b1;
    tick();
    $display("txn flush add: ValidE=%0d RegWriteE=%0d RD1E=%h", bus0.ValidE, bus0.RegWriteE, bus0.RD1E);
    checks++; if (bus0.ValidE !== 1'b0 || bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL flush_bubble: got v=%0d we=%0d want 0/0", bus0.ValidE, bus0.RegWriteE); end
    checks++; if (bus0.RD1E !== 32'd0 || bus0.RdE !== 5'd0) begin errors++; $display("FAIL flush_nop: got rd1e=%h rde=%0d want 0/0", bus0.RD1E, bus0.RdE); end
    flush = 1'b0;
    present(I_LW, 1'b1);
    tick();
    present(I_ADD6, 1'b1); flush = 1'b1;
    #1;
    checks++; if (bus0.LoadUseStall !== 1'b1) begin errors++; $display("FAIL flush_lu_stall: got %0d want 1", bus0.LoadUseStall); end
    tick();
    flush = 1'b0;
    #1;
    $display("txn flush+loaduse: ValidE=%0d Stall=%0d", bus0.ValidE, bus0.LoadUseStall);
    checks++; if (bus0.ValidE !== 1'b0 || bus0.LoadUseStall !== 1'b0) begin errors++; $display("FAIL flush_lu_bubble: got v=%0d stall=%0d want 0/0", bus0.ValidE, bus0.LoadUseStall); end
    tick();
    checks++; if (bus0.ValidE !== 1'b1 || bus0.RdE !== 5'd6) begin errors++; $display("FAIL flush_lu_single: got v=%0d rd=%0d want 1/6", bus0.ValidE, bus0.RdE); end
    $display("txn after flush+loaduse: ValidE=%0d RdE=%0d", bus0.ValidE, bus0.RdE);
  endtask

  task automatic test_illegal();
    present(32'h0000007F, 1'b1);
    tick();
    $display("txn illegal v=1: IllegalE=%0d ValidE=%0d", bus0.IllegalE, bus0.ValidE);
    checks++; if (bus0.IllegalE !== 1'b1) begin errors++; $display("FAIL ill_flag: got %0d want 1", bus0.IllegalE); end
    checks++; if ({bus0.RegWriteE, bus0.MemWriteE, bus0.BranchE, bus0.JumpE} !== 4'b0000) begin
      errors++; $display("FAIL ill_enables: got %b want 0000", {bus0.RegWriteE, bus0.MemWriteE, bus0.BranchE, bus0.JumpE}); end
    present(32'h002091B3, 1'b1);
    tick();
    $display("txn illegal funct3: IllegalE=%0d RegWriteE=%0d", bus0.IllegalE, bus0.RegWriteE);
    checks++; if (bus0.IllegalE !== 1'b1 || bus0.RegWriteE !== 1'b0) begin errors++; $display("FAIL ill_funct3: got ill=%0d we=%0d want 1/0", bus0.IllegalE, bus0.RegWriteE); end
    present(32'h0000007F, 1'b0);
    tick();
    $display("txn illegal v=0: IllegalE=%0d ValidE=%0d", bus0.IllegalE, bus0.ValidE);
    checks++; if (bus0.IllegalE !== 1'b0 || bus0.ValidE !== 1'b0) begin errors++; $display("FAIL ill_invalid: got ill=%0d v=%0d want 0/0", bus0.IllegalE, bus0.ValidE); end
  endtask

  task automatic test_midstream_reset();
    present(I_LW, 1'b1);
    tick();
    present(I_ADD6, 1'b1); rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    $display("txn mid reset: ValidE=%0d ResultSrcE=%b Imm=%h Stall=%0d", bus0.ValidE, bus0.ResultSrcE, bus0.ImmExtE, bus0.LoadUseStall);
    checks++; if (bus0.ValidE !== 1'b0 || bus0.ResultSrcE !== 2'b00 || bus0.ImmExtE !== 32'd0) begin
      errors++; $display("FAIL mid_rst_state: got v=%0d rs=%b imm=%h want 0/00/0", bus0.ValidE, bus0.ResultSrcE, bus0.ImmExtE); end
    checks++; if (bus0.LoadUseStall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %0d want 0", bus0.LoadUseStall); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_store_branch();
    test_alu_ops();
    test_bypass();
    test_load_use();
    test_flush();
    test_illegal();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
